aes_round_engine: RTL and testbench

//  Iterative AES-128 encryption core: one round per clock, with round keys expanded on the fly

---
 rtl/aes_pkg.sv | 27 ++
 rtl/add_round_key.sv | 10 +
 rtl/aes_mix_columns.sv | 24 ++
 rtl/shift_rows.sv | 13 +
 rtl/sub_bytes.sv | 25 ++
 rtl/aes_round_engine.sv | 139 +++++++++++++
 tb/tb_aes_round_engine.sv | 323 ++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the round engine and its sub-blocks.
package aes_pkg;

   typedef logic [3:0][3:0][7:0] state_t;
   typedef logic [3:0][7:0]      word_t;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/add_round_key.sv
// AES AddRoundKey: bitwise XOR of the state with the round key.
module add_round_key (
   input  logic [3:0][3:0][7:0] data,
   input  logic [3:0][3:0][7:0] key,
   output logic [3:0][3:0][7:0] result
);

   assign result = data ^ key;

endmodule

// File: rtl/aes_mix_columns.sv
// AES MixColumns: each column multiplied by the fixed {02,03,01,01} circulant over GF(2^8).
module aes_mix_columns
   import aes_pkg::*;
(
   input  state_t data,
   output state_t result
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;

      // Row 0 sits in the most significant byte of each column word.
      assign a0 = data[c][3];
      assign a1 = data[c][2];
      assign a2 = data[c][1];
      assign a3 = data[c][0];

      assign result[c][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign result[c][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign result[c][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign result[c][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows: row r rotates left by r columns. Column c is word [3-c], row r is byte [3-r].
module shift_rows (
   input  logic [3:0][3:0][7:0] data,
   output logic [3:0][3:0][7:0] result
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign result[3-c][3-r] = data[3-((c+r)%4)][3-r];
      end
   end

endmodule

// File: rtl/sub_bytes.sv
// AES S-box applied to the four bytes of one word.
module sub_bytes
   import aes_pkg::*;
(
   input  logic [3:0][7:0] data,
   output logic [3:0][7:0] result
);

   // Multiplicative inverse as x^254 (0 maps to 0), followed by the FIPS affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (i != 0) inv = gf_mul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign result[b] = sbox(data[b]);
   end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock, round keys expanded on the fly,
// valid/ready handshakes on both sides.
module aes_round_engine
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter bit          REDUCED    = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0][3:0][7:0] in_key,
   input  logic [3:0][3:0][7:0] in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0][3:0][7:0] out_state,
   output logic                 busy
);

   if (NUM_ROUNDS == 0 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
      $error("aes_round_engine: NUM_ROUNDS must be in 1..10");
   end

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   fsm_e       fsm_q, fsm_d;
   state_t     state_q, state_d;
   state_t     rk_q, rk_d, rk_n;
   logic [7:0] rcon_q, rcon_d;
   logic [3:0] rnd_q, rnd_d;

   // Key schedule: column c of the key matrix is FIPS word w[c].
   word_t w0, w1, w2, w3;
   word_t key_sub;
   word_t n0, n1, n2, n3;

   assign w0 = rk_q[3];
   assign w1 = rk_q[2];
   assign w2 = rk_q[1];
   assign w3 = rk_q[0];

   sub_bytes u_key_sbox (
      .data   ({w3[2:0], w3[3]}),
      .result (key_sub)
   );

   assign n0   = w0 ^ key_sub ^ {rcon_q, 24'h000000};
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;
   assign rk_n = {n0, n1, n2, n3};

   // Round datapath.
   state_t sb_state, sr_state, mc_state, pre_key, round_out;
   logic   do_mix;

   for (genvar c = 0; c < 4; c++) begin : g_sbox
      sub_bytes u_sub_bytes (
         .data   (state_q[c]),
         .result (sb_state[c])
      );
   end

   shift_rows u_shift_rows (
      .data   (sb_state),
      .result (sr_state)
   );

   aes_mix_columns u_mix_columns (
      .data   (sr_state),
      .result (mc_state)
   );

   // The final round never mixes; reduced mode never mixes at all.
   assign do_mix  = !REDUCED && (rnd_q != LAST_RND);
   assign pre_key = do_mix ? mc_state : sr_state;

   add_round_key u_add_round_key (
      .data   (pre_key),
      .key    (rk_n),
      .result (round_out)
   );

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rk_d    = rk_q;
      rcon_d  = rcon_q;
      rnd_d   = rnd_q;

      in_ready = rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));

      unique case (fsm_q)
         IDLE: fsm_d = IDLE;
         ROUND: begin
            state_d = round_out;
            rk_d    = rk_n;
            rcon_d  = xtime(rcon_q);
            rnd_d   = rnd_q + 4'd1;
            if (rnd_q == LAST_RND) fsm_d = DONE;
         end
         DONE: begin
            if (out_ready && !in_valid) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase

      // Accept from IDLE, or from DONE on the same edge the result is taken.
      if (in_valid && in_ready) begin
         state_d = in_state ^ in_key;
         rk_d    = in_key;
         rcon_d  = RCON_INIT;
         rnd_d   = 4'd1;
         fsm_d   = ROUND;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rk_q    <= '0;
         rcon_q  <= '0;
         rnd_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         rcon_q  <= rcon_d;
         rnd_q   <= rnd_d;
      end
   end

   assign out_valid = (fsm_q == DONE);
   assign out_state = out_valid ? state_q : '0;
   assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: FIPS-197 vectors, backpressure, back-to-back, reset.
module tb_aes_round_engine;

   localparam int unsigned NR = 10;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_R1  = 128'h01000000010000000100000001000000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_key, in_state, out_state;

   logic         r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready, r1_busy;
   logic [127:0] r1_key, r1_pt, r1_out;

   int tests = 0;
   int fails = 0;

   aes_round_engine #(.NUM_ROUNDS(NR), .REDUCED(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   aes_round_engine #(.NUM_ROUNDS(1), .REDUCED(1'b1)) dut_r1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (r1_in_valid),
      .in_ready  (r1_in_ready),
      .in_key    (r1_key),
      .in_state  (r1_pt),
      .out_valid (r1_out_valid),
      .out_ready (r1_out_ready),
      .out_state (r1_out),
      .busy      (r1_busy)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural AES model ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      while (y != 8'h00) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Inverse found by exhaustive search, then the affine map bit by bit.
   task automatic build_sbox();
      logic [7:0] c63;
      c63 = 8'h63;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt,
                                              input int nr, input bit reduced);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc [10];
      logic [127:0] v, rk;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                  ^ {rc[i/4-1], 24'h000000};
         end
         w[i] = w[i-4] ^ tmp;
      end
      v = pt ^ key;
      for (int r = 1; r <= nr; r++) begin
         for (int n = 0; n < 16; n++) s[n] = sbox_t[v[127-8*n -: 8]];
         for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++) t[row+4*c] = s[row+4*((c+row)%4)];
         if (!reduced && r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         for (int n = 0; n < 16; n++) v[127-8*n -: 8] = t[n] ^ rk[127-8*n -: 8];
      end
      return v;
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic [127:0] exp_q [$];
   int           acc_q [$];
   int           beat_cyc [$];
   int           cyc = 0;
   int           beats = 0;
   logic         prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         acc_q.delete();
         check("reset flags {out_valid,in_ready,busy}", 128'({out_valid, in_ready, busy}), 128'd0);
         check("reset out_state", out_state, 128'd0);
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected out_valid", 128'(out_valid), 128'd0);
            end else begin
               check("ciphertext vs model", out_state, exp_q[0]);
               if (!prev_ov) check("accept-to-valid cycles", 128'(cyc - acc_q[0]), 128'(NR + 1));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
                  beats++;
                  beat_cyc.push_back(cyc);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_enc(in_key, in_state, NR, 1'b0));
            acc_q.push_back(cyc);
         end
      end
      prev_ov = out_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [127:0] k, input logic [127:0] p);
      logic acc;
      @(posedge clk);
      #1;
      in_key   = k;
      in_state = p;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 60 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
      end
      check("send accepted", 128'(acc), 128'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check(name, 128'(seen), 128'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, bc0;
      logic acc;

      in_valid = 1'b0; out_ready = 1'b1; in_key = '0; in_state = '0;
      r1_in_valid = 1'b0; r1_out_ready = 1'b0; r1_key = '0; r1_pt = '0;

      build_sbox();
      check("model App.B", model_enc(KEY_B, PT_B, 10, 1'b0), CT_B);
      check("model App.C.1", model_enc(KEY_C, PT_C, 10, 1'b0), CT_C);
      check("model 1-round reduced", model_enc(128'd0, 128'd0, 1, 1'b1), CT_R1);

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("idle after release {in_ready,busy,out_valid}",
            128'({in_ready, busy, out_valid}), 128'(3'b100));

      // 1: FIPS-197 App.B
      send(KEY_B, PT_B);
      wait_valid("App.B out_valid");
      check("App.B ciphertext", out_state, CT_B);

      // 2: FIPS-197 App.C.1
      send(KEY_C, PT_C);
      wait_valid("App.C.1 out_valid");
      check("App.C.1 ciphertext", out_state, CT_C);

      // 3: one reduced round on the second instance, key=0 pt=0
      @(posedge clk);
      #1 r1_in_valid = 1'b1;
      @(negedge clk);
      check("r1 in_ready", 128'(r1_in_ready), 128'd1);
      @(posedge clk);
      #1 r1_in_valid = 1'b0;
      @(negedge clk);
      check("r1 out_valid during round", 128'({r1_out_valid, r1_busy}), 128'(2'b01));
      @(negedge clk);
      check("r1 out_valid after one round", 128'(r1_out_valid), 128'd1);
      check("r1 ciphertext literal", r1_out, CT_R1);
      check("r1 ciphertext vs model", r1_out, model_enc(r1_key, r1_pt, 1, 1'b1));
      @(posedge clk);
      #1 r1_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("r1 idle after drain", 128'({r1_out_valid, r1_busy}), 128'd0);

      // 4: backpressure
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(KEY_B, PT_B);
      wait_valid("bp out_valid");
      b0 = beats;
      for (int i = 0; i < 20; i++) begin
         check("bp hold {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'(2'b10));
         check("bp hold out_state", out_state, CT_B);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("bp single beat", 128'(beats - b0), 128'd1);
      check("bp out_valid after release", 128'(out_valid), 128'd0);

      // 5: back-to-back, alternating App.B / App.C.1
      b0  = beats;
      bc0 = beat_cyc.size();
      @(posedge clk);
      #1;
      in_key = KEY_B; in_state = PT_B; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         acc = 1'b0;
         for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
         end
         check("b2b accept", 128'(acc), 128'd1);
         @(posedge clk);
         #1;
         if (k == 3) begin
            in_valid = 1'b0;
         end else if (k % 2 == 0) begin
            in_key = KEY_C; in_state = PT_C;
         end else begin
            in_key = KEY_B; in_state = PT_B;
         end
      end
      for (int n = 0; n < 60 && beats < b0 + 4; n++) @(negedge clk);
      check("b2b beat count", 128'(beats - b0), 128'd4);
      if (beat_cyc.size() >= bc0 + 4)
         for (int i = 1; i < 4; i++)
            check("b2b spacing", 128'(beat_cyc[bc0+i] - beat_cyc[bc0+i-1]), 128'(NR + 1));

      // 6: reset during round 5
      send(KEY_C, PT_C);
      repeat (4) @(posedge clk);
      check("busy mid-block", 128'(busy), 128'd1);
      b0 = beats;
      #1 rst = 1'b0;
      #1;
      check("async reset out_state", out_state, 128'd0);
      check("async reset flags {out_valid,busy,in_ready}",
            128'({out_valid, busy, in_ready}), 128'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (15) @(negedge clk);
      check("no output for aborted block", 128'(beats - b0), 128'd0);
      send(KEY_B, PT_B);
      wait_valid("post-reset out_valid");
      check("post-reset ciphertext", out_state, CT_B);
      repeat (2) @(negedge clk);
      check("final idle {in_ready,busy}", 128'({in_ready, busy}), 128'(2'b10));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
